jt49_mix: RTL and testbench

- Output stage directly downstream of the envelope generator. Each sample, it selects fixed volume or envelope level for channels A, B and C.
- Gates each level with its tone/noise mixer state and converts it to an 8-bit amplitude, through a logarithmic table or a linear map.
- Sums the three channels into a 10-bit sound sample.
- Channels are processed sequentially: one shared lookup and one adder.

---
 rtl/jt49_mix_if.sv | 27 ++
 rtl/jt49_mix.sv | 160 ++++++++++++++++
 tb/tb_jt49_mix.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/jt49_mix_if.sv
// Signal bundle between the envelope/tone/noise generators and the jt49 output mixer.
// The master drives sample strobe and channel state; the slave returns the mixed sample.
interface jt49_mix_if;
  logic       cen;
  logic [4:0] env;
  logic [4:0] vol_a;
  logic [4:0] vol_b;
  logic [4:0] vol_c;
  logic       tone_a;
  logic       tone_b;
  logic       tone_c;
  logic       noise;
  logic [5:0] mixer;
  logic [9:0] sound;
  logic       sample;
  logic       overrun;

  modport master (
    output cen, env, vol_a, vol_b, vol_c, tone_a, tone_b, tone_c, noise, mixer,
    input  sound, sample, overrun
  );

  modport slave (
    input  cen, env, vol_a, vol_b, vol_c, tone_a, tone_b, tone_c, noise, mixer,
    output sound, sample, overrun
  );
endinterface

// File: rtl/jt49_mix.sv
// jt49 output mixer: per-channel level select, tone/noise gating, log or linear amplitude,
// and a sequential three-channel sum sharing one lookup and one adder.
module jt49_mix #(
  parameter bit LOGTAB = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  jt49_mix_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CH_A = 3'd1,
    CH_B = 3'd2,
    CH_C = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      env_q, env_d;
  logic [2:0][4:0] vol_q, vol_d;
  logic [2:0]      tone_q, tone_d;
  logic            noise_q, noise_d;
  logic [5:0]      mixer_q, mixer_d;
  logic [9:0]      acc_q, acc_d;
  logic [9:0]      sound_q, sound_d;
  logic            sample_q, sample_d;
  logic            overrun_q, overrun_d;

  logic [1:0]      ch;
  logic [4:0]      ch_vol;
  logic            ch_on;
  logic [4:0]      lvl;
  logic [7:0]      amp;

  // -1.5 dB per step below full scale, index 0 is silence.
  function automatic logic [7:0] log_amp(input logic [4:0] l);
    logic [7:0] a;
    case (l)
      5'd0:  a = 8'd0;    5'd1:  a = 8'd1;    5'd2:  a = 8'd2;    5'd3:  a = 8'd2;
      5'd4:  a = 8'd2;    5'd5:  a = 8'd3;    5'd6:  a = 8'd3;    5'd7:  a = 8'd4;
      5'd8:  a = 8'd5;    5'd9:  a = 8'd6;    5'd10: a = 8'd7;    5'd11: a = 8'd8;
      5'd12: a = 8'd10;   5'd13: a = 8'd11;   5'd14: a = 8'd14;   5'd15: a = 8'd16;
      5'd16: a = 8'd19;   5'd17: a = 8'd23;   5'd18: a = 8'd27;   5'd19: a = 8'd32;
      5'd20: a = 8'd38;   5'd21: a = 8'd45;   5'd22: a = 8'd54;   5'd23: a = 8'd64;
      5'd24: a = 8'd76;   5'd25: a = 8'd90;   5'd26: a = 8'd108;  5'd27: a = 8'd128;
      5'd28: a = 8'd152;  5'd29: a = 8'd181;  5'd30: a = 8'd215;  default: a = 8'd255;
    endcase
    return a;
  endfunction

  // Shared datapath: the FSM state picks which snapshotted channel feeds the lookup.
  always_comb begin
    unique case (state_q)
      CH_B:    ch = 2'd1;
      CH_C:    ch = 2'd2;
      default: ch = 2'd0;
    endcase

    ch_vol = vol_q[ch];
    ch_on  = (tone_q[ch] | mixer_q[2:0][ch]) & (noise_q | mixer_q[5:3][ch]);

    if (!ch_on) begin
      lvl = 5'd0;
    end else if (ch_vol[4]) begin
      lvl = env_q;
    end else if (ch_vol[3:0] == 4'd0) begin
      lvl = 5'd0;
    end else begin
      lvl = {ch_vol[3:0], 1'b1};
    end

    amp = LOGTAB ? log_amp(lvl) : {lvl, lvl[4:2]};
  end

  // NOTE: every next-state signal gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    env_d     = env_q;
    vol_d     = vol_q;
    tone_d    = tone_q;
    noise_d   = noise_q;
    mixer_d   = mixer_q;
    acc_d     = acc_q;
    sound_d   = sound_q;
    sample_d  = 1'b0;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cen) begin
          env_d   = bus.env;
          vol_d   = {bus.vol_c, bus.vol_b, bus.vol_a};
          tone_d  = {bus.tone_c, bus.tone_b, bus.tone_a};
          noise_d = bus.noise;
          mixer_d = bus.mixer;
          acc_d   = 10'd0;
          state_d = CH_A;
        end
      end
      CH_A: begin
        acc_d   = acc_q + {2'b00, amp};
        state_d = CH_B;
      end
      CH_B: begin
        acc_d   = acc_q + {2'b00, amp};
        state_d = CH_C;
      end
      CH_C: begin
        acc_d   = acc_q + {2'b00, amp};
        state_d = DONE;
      end
      DONE: begin
        sound_d  = acc_q;
        sample_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A strobe outside IDLE is dropped; the sticky flag records that a sample was lost.
    if (bus.cen && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      env_q     <= '0;
      vol_q     <= '0;
      tone_q    <= '0;
      noise_q   <= 1'b0;
      mixer_q   <= '0;
      acc_q     <= '0;
      sound_q   <= '0;
      sample_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      env_q     <= env_d;
      vol_q     <= vol_d;
      tone_q    <= tone_d;
      noise_q   <= noise_d;
      mixer_q   <= mixer_d;
      acc_q     <= acc_d;
      sound_q   <= sound_d;
      sample_q  <= sample_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.sound   = sound_q;
  assign bus.sample  = sample_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_jt49_mix.sv
// Self-checking bench for jt49_mix: log and linear instances driven in lockstep and
// compared against a closed-form model of the channel mixing rules.
module tb_jt49_mix;

  typedef struct packed {
    logic [4:0]      env;
    logic [2:0][4:0] vol;
    logic [2:0]      tone;
    logic            noise;
    logic [5:0]      mixer;
  } stim_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  jt49_mix_if if_log ();
  jt49_mix_if if_lin ();

  jt49_mix #(.LOGTAB(1'b1)) u_log (.clk(clk), .rst(rst), .bus(if_log));
  jt49_mix #(.LOGTAB(1'b0)) u_lin (.clk(clk), .rst(rst), .bus(if_lin));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Amplitude from level: attenuation in dB for the log curve, bit replication for linear.
  function automatic int amp_of(input bit logtab, input int lvl);
    if (lvl == 0) return 0;
    if (logtab) return $rtoi(255.0 * $pow(10.0, -(31 - lvl) * 1.5 / 20.0) + 0.5);
    return lvl * 8 + lvl / 4;
  endfunction

  function automatic int model(input bit logtab, input stim_t s);
    int sum = 0;
    for (int c = 0; c < 3; c++) begin
      bit on;
      int lvl;
      on = (s.tone[c] || s.mixer[c]) && (s.noise || s.mixer[c+3]);
      if (s.vol[c][4]) lvl = s.env;
      else if (s.vol[c][3:0] == 0) lvl = 0;
      else lvl = 2 * s.vol[c][3:0] + 1;
      if (!on) lvl = 0;
      sum += amp_of(logtab, lvl);
    end
    return sum;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.env   = 5'($urandom);
    s.vol   = 15'($urandom);
    s.tone  = 3'($urandom);
    s.noise = 1'($urandom);
    s.mixer = 6'($urandom);
    return s;
  endfunction

  function automatic stim_t mk(input logic [4:0] env, input logic [4:0] va, input logic [4:0] vb,
                               input logic [4:0] vc, input logic [2:0] tone, input logic noise,
                               input logic [5:0] mixer);
    stim_t s;
    s.env = env; s.vol = {vc, vb, va}; s.tone = tone; s.noise = noise; s.mixer = mixer;
    return s;
  endfunction

  task automatic drive(input stim_t s, input logic c);
    if_log.cen = c;    if_lin.cen = c;
    if_log.env = s.env; if_lin.env = s.env;
    if_log.vol_a = s.vol[0]; if_lin.vol_a = s.vol[0];
    if_log.vol_b = s.vol[1]; if_lin.vol_b = s.vol[1];
    if_log.vol_c = s.vol[2]; if_lin.vol_c = s.vol[2];
    if_log.tone_a = s.tone[0]; if_lin.tone_a = s.tone[0];
    if_log.tone_b = s.tone[1]; if_lin.tone_b = s.tone[1];
    if_log.tone_c = s.tone[2]; if_lin.tone_c = s.tone[2];
    if_log.noise = s.noise; if_lin.noise = s.noise;
    if_log.mixer = s.mixer; if_lin.mixer = s.mixer;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One pass: strobe s, then scramble the inputs with 'after' to prove the snapshot.
  task automatic run_pass(input string tag, input stim_t s, input stim_t after);
    int n = 0;
    @(negedge clk);
    drive(s, 1'b1);
    @(posedge clk);
    #1 drive(after, 1'b0);
    while (n < 10) begin
      @(posedge clk);
      #1 n++;
      if (if_log.sample) break;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_sample_lin"}, int'(if_lin.sample), 1);
    check({tag, "_sound_log"}, int'(if_log.sound), model(1'b1, s));
    check({tag, "_sound_lin"}, int'(if_lin.sound), model(1'b0, s));
    @(posedge clk);
    #1 check({tag, "_pulse_end"}, int'(if_log.sample), 0);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 if (if_log.sample) pulses++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s, s2;
    int    pulses;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    drive('0, 1'b0);
    do_reset();

    check("rst_sound", int'(if_log.sound), 0);
    check("rst_sample", int'(if_log.sample), 0);
    check("rst_overrun", int'(if_log.overrun), 0);
    check("rst_sound_lin", int'(if_lin.sound), 0);

    s = mk(5'd0, 5'h0F, 5'h0F, 5'h0F, 3'b000, 1'b0, 6'h3F);
    run_pass("full", s, s);
    s = mk(5'd27, 5'h10, 5'h00, 5'h00, 3'b000, 1'b0, 6'h3F);
    run_pass("env27", s, s);
    s = mk(5'd0, 5'h0F, 5'h00, 5'h00, 3'b000, 1'b0, 6'b111110);
    run_pass("toneA_lo", s, s);
    s.tone = 3'b001;
    run_pass("toneA_hi", s, s);

    // Snapshot: vol_a drops to 0 one clock after the strobe; next pass sees the new value.
    s  = mk(5'd0, 5'h0F, 5'h00, 5'h00, 3'b000, 1'b0, 6'h3F);
    s2 = s;
    s2.vol[0] = 5'h00;
    run_pass("snap", s, s2);
    run_pass("snap_next", s2, s2);
    check("no_overrun_yet", int'(if_log.overrun), 0);

    for (int i = 0; i < 40; i++) begin
      run_pass($sformatf("rnd%0d", i), rand_stim(), rand_stim());
    end

    // Second strobe two clocks into a pass is dropped and flagged.
    s  = mk(5'd0, 5'h0F, 5'h0F, 5'h0F, 3'b000, 1'b0, 6'h3F);
    s2 = mk(5'd0, 5'h01, 5'h00, 5'h00, 3'b000, 1'b0, 6'h3F);
    @(negedge clk);
    drive(s, 1'b1);
    @(posedge clk);
    #1 drive(s, 1'b0);
    @(posedge clk);
    #1 drive(s2, 1'b1);
    @(posedge clk);
    #1 drive(s2, 1'b0);
    count_pulses(8, pulses);
    check("ovr_pulses", pulses, 1);
    check("ovr_sound", int'(if_log.sound), model(1'b1, s));
    check("ovr_flag", int'(if_log.overrun), 1);
    check("ovr_flag_lin", int'(if_lin.overrun), 1);
    run_pass("ovr_after", s2, s2);
    check("ovr_sticky", int'(if_log.overrun), 1);

    // Reset during CH_B aborts the pass and clears everything.
    run_pass("pre_abort", s, s);
    @(negedge clk);
    drive(s, 1'b1);
    @(posedge clk);
    #1 drive(s, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_sound", int'(if_log.sound), 0);
    check("abort_overrun", int'(if_log.overrun), 0);
    count_pulses(6, pulses);
    check("abort_pulses", pulses, 0);

    // Reset takes priority over a coincident strobe.
    @(negedge clk);
    drive(s, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(s, 1'b0);
    count_pulses(6, pulses);
    check("rst_cen_pulses", pulses, 0);
    check("rst_cen_sound", int'(if_log.sound), 0);

    run_pass("post_abort", s, rand_stim());
    check("post_overrun", int'(if_log.overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
